// File: rtl/prg_pkg.sv
// Shared types and constants for the PRG RAM write path.
package prg_pkg;

  localparam int PRG_ADDR_BITS = 23;
  localparam logic [1:0] WM_NONE = 2'b11;

  typedef struct packed {
    logic [PRG_ADDR_BITS-1:0] addr;
    logic [7:0]               data;
  } wr_entry_t;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } wr_state_t;

  // A set wm bit masks its byte: odd addresses write [15:8], even write [7:0].
  function automatic logic [1:0] wm_for(input logic lsb);
    return lsb ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/sdram_bus.sv
// SDRAM port with req/ack toggle handshake; the controller owns req, the memory owns ack.
interface sdram_bus #(parameter int AW = 22);
  logic          req;
  logic          ack;
  logic          we;
  logic [AW-1:0] address;
  logic [15:0]   data_write;
  logic [1:0]    wm;

  modport controller (output req, we, address, data_write, wm, input ack);
  modport memory     (input req, we, address, data_write, wm, output ack);
endinterface

// File: rtl/prg_ram_writer_fifo.sv
// Small write queue; a push on a full queue is taken only when a pop happens in the same cycle.
module wr_fifo
  import prg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  wr_entry_t i_data,
  input  logic      i_pop,
  output wr_entry_t o_head,
  output logic      o_full,
  output logic      o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] r_wptr;
  logic [PW:0] r_rptr;
  wr_entry_t   r_mem [DEPTH];
  logic        w_push_ok;
  logic        w_pop_ok;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_head    = r_mem[r_rptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr[PW-1:0]] <= i_data;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/prg_ram_writer.sv
// Captures cartridge-bus byte writes, queues them and issues masked word writes to SDRAM.
module prg_ram_writer
  import prg_pkg::*;
#(
  parameter int ADDR_BITS = PRG_ADDR_BITS,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sdram_bus.controller         ram,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           data_in,
  output logic                 inval,
  output logic [ADDR_BITS-2:0] inval_addr,
  output logic                 busy,
  output logic                 overflow
);

  logic [3:0] r_sync;
  logic       w_edge;
  logic       w_full;
  logic       w_empty;
  wr_entry_t  w_head;
  wr_entry_t  w_entry;
  wr_state_t  r_state;
  wr_state_t  w_next;
  logic       w_issue;
  logic       w_done;

  assign w_edge  = (r_sync[3:1] == 3'b011);
  assign w_entry = '{addr: addr, data: data_in};
  assign busy    = !w_empty || (r_state != IDLE);

  wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_edge),
    .i_data  (w_entry),
    .i_pop   (w_issue),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync  <= 4'b0000;
      r_state <= IDLE;
    end else begin
      r_sync  <= {r_sync[2:0], we};
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && (ram.req == ram.ack)) begin
          w_issue = 1'b1;
          w_next  = WAIT_ACK;
        end else begin
          w_next = IDLE;
        end
      end
      WAIT_ACK: begin
        if (ram.req == ram.ack) begin
          w_done = 1'b1;
          w_next = IDLE;
        end else begin
          w_next = WAIT_ACK;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Handshake fields change only on issue/completion, so they stay stable while req != ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram.req        <= 1'b0;
      ram.we         <= 1'b0;
      ram.address    <= '0;
      ram.data_write <= 16'h0000;
      ram.wm         <= WM_NONE;
      inval          <= 1'b0;
      inval_addr     <= '0;
      overflow       <= 1'b0;
    end else begin
      inval <= 1'b0;
      if (w_issue) begin
        ram.req        <= ~ram.req;
        ram.we         <= 1'b1;
        ram.address    <= w_head.addr[ADDR_BITS-1:1];
        ram.data_write <= {w_head.data, w_head.data};
        ram.wm         <= wm_for(w_head.addr[0]);
        inval          <= 1'b1;
        inval_addr     <= w_head.addr[ADDR_BITS-1:1];
      end else if (w_done) begin
        ram.we <= 1'b0;
        ram.wm <= WM_NONE;
      end
      if (w_edge && w_full && !w_issue) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prg_ram_writer.sv
// Bench for prg_ram_writer: acts as the SDRAM side and scoreboards every issued word write.
module tb_prg_ram_writer;
  import prg_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [22:0] addr;
  logic [7:0]  data_in;
  logic        inval;
  logic [21:0] inval_addr;
  logic        busy;
  logic        overflow;

  sdram_bus #(.AW(22)) ram_if ();

  prg_ram_writer #(.ADDR_BITS(23), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .ram        (ram_if),
    .we         (we),
    .addr       (addr),
    .data_in    (data_in),
    .inval      (inval),
    .inval_addr (inval_addr),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int        vectors    = 0;
  int        miscompares = 0;
  int        issues     = 0;
  int        cyc        = 0;
  int        ack_delay  = 2;
  int        ack_cnt    = 0;
  int        ack_cycle  = -1;
  bit        ack_hold   = 1'b0;
  bit        manual     = 1'b0;
  logic      prev_req   = 1'b0;
  logic [21:0] held_addr;
  logic [17:0] held_dw;
  wr_entry_t exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard on issue, hold check while pending, then the memory's ack response.
  always @(negedge clk) begin
    if (!reset) begin
      prev_req   = 1'b0;
      ram_if.ack = 1'b0;
      ack_cnt    = 0;
    end else begin
      if (ram_if.req !== prev_req) begin
        wr_entry_t e;
        issues++;
        prev_req = ram_if.req;
        if (exp_q.size() == 0) begin
          chk("spurious_issue", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("address", 32'(ram_if.address), 32'(e.addr >> 1));
          chk("data_write", 32'(ram_if.data_write), 32'(e.data) * 32'h101);
          chk("wm", 32'(ram_if.wm), e.addr[0] ? 32'd1 : 32'd2);
          chk("we_issue", 32'(ram_if.we), 32'd1);
          chk("inval_pulse", 32'(inval), 32'd1);
          chk("inval_addr", 32'(inval_addr), 32'(e.addr >> 1));
        end
        held_addr = ram_if.address;
        held_dw   = {ram_if.wm, ram_if.data_write};
      end else begin
        chk("inval_extra", 32'(inval), 32'd0);
        if (ram_if.req !== ram_if.ack) begin
          chk("hold_addr", 32'(ram_if.address), 32'(held_addr));
          chk("hold_wm_data", 32'({ram_if.wm, ram_if.data_write}), 32'(held_dw));
        end
      end
      if (manual) begin
        if (cyc == ack_cycle && ram_if.req !== ram_if.ack) ram_if.ack = ram_if.req;
      end else if (ram_if.req !== ram_if.ack && !ack_hold) begin
        if (ack_cnt >= ack_delay) begin
          ram_if.ack = ram_if.req;
          ack_cnt    = 0;
        end else begin
          ack_cnt++;
        end
      end
    end
  end

  task automatic strobe(input logic [22:0] a, input logic [7:0] d, input int hold,
                        input int gap, input bit accept);
    @(negedge clk);
    addr = a; data_in = d; we = 1'b1;
    if (accept) exp_q.push_back('{addr: a, data: d});
    repeat (hold) @(negedge clk);
    we = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy !== 1'b0 || ram_if.req !== ram_if.ack) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk(tag, 32'(n < 500), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base;
    reset = 1'b0; we = 1'b0; addr = '0; data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(ram_if.req), 32'd0);
    chk("rst_we", 32'(ram_if.we), 32'd0);
    chk("rst_address", 32'(ram_if.address), 32'd0);
    chk("rst_data", 32'(ram_if.data_write), 32'd0);
    chk("rst_wm", 32'(ram_if.wm), 32'd3);
    chk("rst_inval", 32'({inval, inval_addr}), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    ack_delay = 5;
    base = issues;
    strobe(23'h000101, 8'hA5, 3, 1, 1'b1);
    chk("single_busy", 32'(busy), 32'd1);
    wait_idle("single_timeout");
    chk("single_issues", 32'(issues - base), 32'd1);
    chk("single_idle", 32'({busy, ram_if.we, ram_if.wm}), 32'd3);

    base = issues;
    strobe(23'h000100, 8'h3C, 3, 3, 1'b1);
    wait_idle("even_timeout");
    chk("even_issues", 32'(issues - base), 32'd1);

    ack_delay = 1;
    base = issues;
    strobe(23'h12345B, 8'h77, 40, 3, 1'b1);
    wait_idle("long_timeout");
    chk("long_issues", 32'(issues - base), 32'd1);

    // Fill queue behind a stalled write, then time the 6th strobe's push onto the pop.
    manual = 1'b1; ack_cycle = -1;
    base = issues;
    for (int i = 0; i < 5; i++) strobe(23'(32'h2000 + i), 8'(8'h10 + i), 3, 2, 1'b1);
    @(negedge clk);
    addr = 23'h2005; data_in = 8'h15; we = 1'b1;
    exp_q.push_back('{addr: 23'h2005, data: 8'h15});
    ack_cycle = cyc + 2;
    repeat (4) @(negedge clk);
    we = 1'b0;
    repeat (3) @(negedge clk);
    chk("fullpop_overflow", 32'(overflow), 32'd0);
    manual = 1'b0; ack_delay = 0;
    wait_idle("fullpop_timeout");
    chk("fullpop_issues", 32'(issues - base), 32'd6);
    chk("fullpop_overflow_end", 32'(overflow), 32'd0);

    ack_hold = 1'b1;
    base = issues;
    for (int i = 0; i < 6; i++) strobe(23'(32'h3000 + 2 * i), 8'(8'hC0 + i), 3, 2, i < 5);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_busy", 32'(busy), 32'd1);
    chk("ovf_first_only", 32'(issues - base), 32'd1);
    ack_hold = 1'b0;
    wait_idle("ovf_timeout");
    chk("ovf_issues", 32'(issues - base), 32'd5);

    base = 0;
    for (int b = 0; b < 10; b++) begin
      int n;
      int was;
      ack_delay = $urandom_range(0, 6);
      n   = $urandom_range(1, 4);
      was = issues;
      for (int i = 0; i < n; i++) begin
        strobe(23'($urandom), 8'($urandom_range(0, 255)), $urandom_range(2, 8),
               $urandom_range(2, 5), 1'b1);
      end
      wait_idle("rand_timeout");
      chk("rand_issues", 32'(issues - was), 32'(n));
    end
    chk("ovf_sticky", 32'(overflow), 32'd1);

    ack_hold = 1'b1;
    strobe(23'h004444, 8'h44, 3, 2, 1'b1);
    strobe(23'h005555, 8'h55, 3, 2, 1'b1);
    chk("pre_rst_pending", 32'(ram_if.req !== ram_if.ack), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_req", 32'(ram_if.req), 32'd0);
    chk("mid_rst_we", 32'(ram_if.we), 32'd0);
    chk("mid_rst_wm", 32'(ram_if.wm), 32'd3);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    exp_q.delete();
    ack_hold = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    base = issues;
    repeat (10) @(negedge clk);
    chk("post_rst_quiet", 32'(issues - base), 32'd0);
    chk("post_rst_ack", 32'(ram_if.ack), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
